// File: rtl/scan_mux.sv
// Time-multiplexed digit scanner: steps a one-hot select across NUM_DIGITS digits, holding each for SCAN_DIV cycles.
// Optional leading-zero blanking is enabled by defining SCAN_MUX_LZB_EN.
module scan_mux #(
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_W    = 4,
   parameter int SCAN_DIV   = 1000
) (
   input  logic                          clk_scan_mux,
   input  logic                          rst_scan_mux,
   input  logic                          en_in,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]         blank_mask_in,
   output logic [DIGIT_W-1:0]            digit_out,
   output logic [NUM_DIGITS-1:0]         digit_sel_out,
   output logic                          frame_start_out
);

   localparam int                 IDX_W      = $clog2(NUM_DIGITS);
   localparam logic [DIGIT_W-1:0] NULL_CODE  = '1;
   localparam logic [15:0]        LAST_PRESC = 16'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t                        state_q, state_d;
   logic [15:0]                   presc_q, presc_d;
   logic [IDX_W-1:0]              index_q, index_d;
   logic [NUM_DIGITS*DIGIT_W-1:0] frameDigits_q, frameDigits_d;
   logic [NUM_DIGITS-1:0]         frameBlank_q, frameBlank_d;
   logic [DIGIT_W-1:0]            digit_q, digit_d;
   logic [NUM_DIGITS-1:0]         sel_q, sel_d;
   logic                          frameStart_q, frameStart_d;

   logic [NUM_DIGITS-1:0]         lzbMask;
   logic                          tick;
   logic                          capture;

`ifdef SCAN_MUX_LZB_EN
   // A digit is blanked when it and every more-significant digit are zero; digit 0 always shows.
   always_comb begin
      logic higherZero;
      lzbMask    = '0;
      higherZero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         higherZero = higherZero && (digits_in[i*DIGIT_W +: DIGIT_W] == '0);
         lzbMask[i] = higherZero;
      end
   end
`else
   assign lzbMask = '0;
`endif

   assign tick = (presc_q == LAST_PRESC);

   always_comb begin
      state_d       = state_q;
      presc_d       = presc_q;
      index_d       = index_q;
      frameDigits_d = frameDigits_q;
      frameBlank_d  = frameBlank_q;
      frameStart_d  = 1'b0;
      capture       = 1'b0;
      digit_d       = NULL_CODE;
      sel_d         = '0;

      case (state_q)
         IDLE: begin
            presc_d = '0;
            index_d = '0;
            if (en_in) begin
               state_d = SCAN;
               capture = 1'b1;
            end
         end
         SCAN: begin
            if (!en_in) begin
               state_d = IDLE;
               presc_d = '0;
               index_d = '0;
            end else if (tick) begin
               presc_d = '0;
               if (index_q == LAST_IDX) begin
                  index_d = '0;
                  capture = 1'b1;
               end else begin
                  index_d = index_q + 1'b1;
               end
            end else begin
               presc_d = presc_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
            index_d = '0;
         end
      endcase

      if (capture) begin
         frameDigits_d = digits_in;
         frameBlank_d  = blank_mask_in | lzbMask;
         frameStart_d  = 1'b1;
      end

      // Outputs are computed from next-state values so they move on the same edge as the index.
      if (state_d == SCAN) begin
         digit_d = frameBlank_d[index_d] ? NULL_CODE : frameDigits_d[index_d*DIGIT_W +: DIGIT_W];
         sel_d   = NUM_DIGITS'(1) << index_d;
      end
   end

   always_ff @(posedge clk_scan_mux) begin
      if (rst_scan_mux) begin
         state_q       <= IDLE;
         presc_q       <= '0;
         index_q       <= '0;
         frameDigits_q <= '0;
         frameBlank_q  <= '0;
         digit_q       <= NULL_CODE;
         sel_q         <= '0;
         frameStart_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         index_q       <= index_d;
         frameDigits_q <= frameDigits_d;
         frameBlank_q  <= frameBlank_d;
         digit_q       <= digit_d;
         sel_q         <= sel_d;
         frameStart_q  <= frameStart_d;
      end
   end

   assign digit_out       = digit_q;
   assign digit_sel_out   = sel_q;
   assign frame_start_out = frameStart_q;

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter DIGIT_W, default 4, width of each digit code, legal range 4..8.
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is held, legal range 1..65535.
REQ-004 SHALL have port clk_scan_mux  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_scan_mux  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port en_in  input  1  scan enable.
REQ-007 SHALL have port digits_in  input  NUM_DIGITS*DIGIT_W  packed digits; digit i at bits [i*DIGIT_W +: DIGIT_W]; digit 0 least significant.
REQ-008 SHALL have port blank_mask_in  input  NUM_DIGITS  bit i=1 forces digit i to NULL.
REQ-009 SHALL have port digit_out  output  DIGIT_W  registered code of the active digit.
REQ-010 SHALL have port digit_sel_out  output  NUM_DIGITS  registered one-hot active-digit select.
REQ-011 SHALL have port frame_start_out  output  1  registered one-cycle pulse when digit 0 becomes active.

Function
REQ-012 SHALL define NULL as all-ones of DIGIT_W bits.
REQ-013 SHALL implement two states: IDLE and SCAN.
REQ-014 IDLE: digit_out=NULL, digit_sel_out=0, frame_start_out=0, prescaler=0, index=0.
REQ-015 IDLE->SCAN when en_in=1 at an edge: index<=0, prescaler<=0, digits_in and blank_mask_in captured into frame registers, frame_start_out=1.
REQ-016 SCAN->IDLE when en_in=0 at any edge, including a tick edge; outputs take IDLE values on that edge.
REQ-017 In SCAN, prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = prescaler==SCAN_DIV-1; with SCAN_DIV=1, tick every cycle.
REQ-018 On tick, index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-019 On a wrap to 0, digits_in and blank_mask_in SHALL be recaptured and frame_start_out pulses for exactly one cycle.
REQ-020 Changes to digits_in or blank_mask_in mid-frame SHALL have no effect until the next capture.
REQ-021 digit_out and digit_sel_out SHALL update on the same edge as the index: first digit visible in the cycle after en_in is sampled high.
REQ-022 In SCAN, digit_sel_out SHALL equal 1<<index.
REQ-023 In SCAN, digit_out SHALL equal captured digit[index], or NULL if that digit is blanked.
REQ-024 Each digit SHALL be held for exactly SCAN_DIV cycles; frame period = NUM_DIGITS*SCAN_DIV cycles.

Reset
REQ-025 rst_scan_mux=1 at an edge SHALL force IDLE and clear prescaler, index and frame registers to 0; outputs take IDLE values.
REQ-026 Reset SHALL dominate en_in and tick.
REQ-027 Reset asserted mid-frame SHALL abort the frame; the first cycle after release behaves as IDLE.

Configuration
REQ-028 Macro SCAN_MUX_LZB_EN SHALL control leading-zero blanking.
REQ-029 With SCAN_MUX_LZB_EN defined, captured digit i (i>=1) SHALL be blanked when digit i and all higher digits are 0; digit 0 is never blanked by this rule; blank_mask_in is still ORed in.
REQ-030 With SCAN_MUX_LZB_EN undefined, only blank_mask_in SHALL blank digits.

Verification (NUM_DIGITS=4, DIGIT_W=4, SCAN_DIV=3 unless stated)
REQ-031 digits_in=16'h4321, mask=0, en_in rises -> sel 0001/digit 1 for 3 cycles, then 0010/2, 0100/3, 1000/4; frame_start_out high on the first cycle and again at cycle 12.
REQ-032 digits_in changed to 16'h8765 during digit 2 -> digits 2-3 still show 3,4; next frame shows 5,6,7,8.
REQ-033 en_in falls on a tick edge -> next cycle digit_out=4'hF, sel=0000; en_in re-raised -> restarts at digit 0 with frame_start_out=1.
REQ-034 rst_scan_mux pulsed 1 cycle during digit 1 with en_in=1 -> IDLE values on the reset edge; scan restarts at digit 0 on the edge after release.
REQ-035 SCAN_MUX_LZB_EN defined, digits_in=16'h0050 -> digit 3 = 4'hF, digit 2 = 4'hF, digit 1 = 5, digit 0 = 0; digits_in=16'h0000 -> only digit 0 shows 0. Without macro -> 0,0,5,0 shown.
REQ-036 SCAN_DIV=1, NUM_DIGITS=2 -> sel alternates 01/10 every cycle; frame_start_out asserted every 2nd cycle.
